// File: rtl/alu_mul_seq_if.sv
// rtl/alu_mul_seq_if.sv - requester-side start/ready/done bundle for alu_mul_seq
interface alu_mul_seq_if;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        ready;
    logic        done;
    logic [15:0] product;
    logic        zr;
    logic        ng;

    modport master (output start, a, b, input ready, done, product, zr, ng);
    modport slave  (input start, a, b, output ready, done, product, zr, ng);
endinterface

// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - shift-and-add 16-bit multiplier that sequences an external ALU
module alu_mul_seq #(
    parameter int ITER       = 16,
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_mul_seq_if.slave req,
    output logic [15:0] alu_x,
    output logic [15:0] alu_y,
    output logic        alu_zx,
    output logic        alu_nx,
    output logic        alu_zy,
    output logic        alu_ny,
    output logic        alu_f,
    output logic        alu_no,
    input  logic [15:0] alu_out,
    input  logic        alu_zr,
    input  logic        alu_ng
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADD  = 2'd1;
    localparam logic [1:0] S_DBL  = 2'd2;
    localparam logic [1:0] S_FLAG = 2'd3;

    // ALU control words ordered {zx,nx,zy,ny,f,no}
    localparam logic [5:0] C_ADD   = 6'b000010;
    localparam logic [5:0] C_PASSX = 6'b001100;
    localparam logic [5:0] C_ZERO  = 6'b101010;

    localparam logic [4:0]  CNT_LAST = 5'(ITER - 1);
    localparam logic [15:0] B_MASK   = 16'hFFFF >> (16 - ITER);

    logic [1:0]  state;
    logic [15:0] acc;
    logic [15:0] mcand;
    logic [15:0] mplier;
    logic [4:0]  cnt;
    logic        done_q;
    logic [15:0] product_q;
    logic        zr_q;
    logic        ng_q;
    logic [5:0]  ctrl;
    logic [15:0] mplier_shr;
    logic        last_iter;

    assign mplier_shr = {1'b0, mplier[15:1]};
    assign last_iter  = (cnt == CNT_LAST) || (EARLY_EXIT && (mplier_shr == 16'd0));

    assign req.ready   = (state == S_IDLE);
    assign req.done    = done_q;
    assign req.product = product_q;
    assign req.zr      = zr_q;
    assign req.ng      = ng_q;

    always_comb begin
        ctrl  = C_ZERO;
        alu_x = 16'd0;
        alu_y = 16'd0;
        case (state)
            S_ADD: begin
                alu_x = acc;
                if (mplier[0]) begin
                    ctrl  = C_ADD;
                    alu_y = mcand;
                end else begin
                    ctrl = C_PASSX;
                end
            end
            S_DBL: begin
                ctrl  = C_ADD;
                alu_x = mcand;
                alu_y = mcand;
            end
            S_FLAG: begin
                ctrl  = C_PASSX;
                alu_x = acc;
            end
            default: ;
        endcase
    end

    assign {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = ctrl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            acc       <= 16'd0;
            mcand     <= 16'd0;
            mplier    <= 16'd0;
            cnt       <= 5'd0;
            done_q    <= 1'b0;
            product_q <= 16'd0;
            zr_q      <= 1'b1;
            ng_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req.start) begin
                        acc    <= 16'd0;
                        mcand  <= req.a;
                        mplier <= req.b & B_MASK;
                        cnt    <= 5'd0;
                        state  <= S_ADD;
                    end
                end
                S_ADD: begin
                    acc   <= alu_out;
                    state <= S_DBL;
                end
                S_DBL: begin
                    mcand  <= alu_out;
                    mplier <= mplier_shr;
                    cnt    <= cnt + 5'd1;
                    state  <= last_iter ? S_FLAG : S_ADD;
                end
                default: begin
                    product_q <= alu_out;
                    zr_q      <= alu_zr;
                    ng_q      <= alu_ng;
                    done_q    <= 1'b1;
                    state     <= S_IDLE;
                end
            endcase
        end
    end
endmodule
